bg_column_loader: RTL
=====================

BG_COLUMN_LOADER -- requirements
Module: bg_column_loader

Interface
REQ-001 SHALL have parameter MAP_COLS, default 40, tile-map columns held in bg_ram.
REQ-002 SHALL have parameter MAP_ROWS, default 30, tile-map rows; bg_ram address = row*MAP_COLS + col.
REQ-003 SHALL have parameter LEVEL_COLS, default 256, number of columns in the level ROM.
REQ-004 SHALL have parameter ROM_LAT, default 2, level-ROM read latency in cycles (HIGH_PERFORMANCE ram).
REQ-005 SHALL have port clk, input, 1, system clock (100 MHz board clock).
REQ-006 SHALL have port clr, input, 1; reset is asynchronous and active-low.
REQ-007 SHALL have port f_tick, input, 1, one-cycle pulse at start of vertical blanking.
REQ-008 SHALL have port video_on, input, 1, high while the beam is in the visible area.
REQ-009 SHALL have port req, input, 1, column-load request from the game engine.
REQ-010 SHALL have port level_col, input, 8, source column in the level ROM.
REQ-011 SHALL have port dst_col, input, 6, destination column in bg_ram.
REQ-012 SHALL have port busy, output, 1, high from request acceptance until done.
REQ-013 SHALL have port done, output, 1, one-cycle pulse after the last write.
REQ-014 SHALL have port err, output, 1, one-cycle pulse on a rejected request.
REQ-015 SHALL have port rom_addr, output, 13, level-ROM address = level_col*MAP_ROWS + row.
REQ-016 SHALL have port rom_data, input, 9, level-ROM tile index.
REQ-017 SHALL have ports ram_addr (output, 16), ram_din (output, 9) and ram_we (output, 1), forming the bg_ram port-A write interface.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT_VBL, READ, DRAIN, FINISH.
REQ-019 IDLE with req=1 and valid arguments SHALL latch level_col and dst_col, go to WAIT_VBL, and drive busy=1 from the next cycle.
REQ-020 A request SHALL be valid when dst_col < MAP_COLS and level_col < LEVEL_COLS; an invalid request SHALL pulse err for 1 cycle, stay in IDLE, and perform no writes.
REQ-021 req while busy=1 SHALL be ignored (no latch, no err).
REQ-022 WAIT_VBL SHALL go to READ on f_tick; an f_tick in the same cycle as request acceptance SHALL NOT be consumed.
REQ-023 READ SHALL issue one ROM read per cycle, rows 0..MAP_ROWS-1, then go to DRAIN.
REQ-024 Each write SHALL occur exactly ROM_LAT cycles after its read, with ram_we=1, ram_din=rom_data, ram_addr=row*MAP_COLS+dst_col for the matching row.
REQ-025 DRAIN SHALL last ROM_LAT cycles, completing the outstanding writes, then go to FINISH.
REQ-026 Total time from f_tick to the last write SHALL be MAP_ROWS+ROM_LAT cycles.
REQ-027 FINISH SHALL pulse done for 1 cycle, drop busy in the same cycle, and return to IDLE.
REQ-028 ram_we SHALL never be 1 while video_on=1.
REQ-029 If video_on rises during READ or DRAIN, the module SHALL squash all in-flight writes that cycle, return to WAIT_VBL, and restart from row 0 on the next f_tick; rows already written are rewritten.
REQ-030 Row counter and address arithmetic SHALL be unsigned, with no wrap: the maximum ram_addr is 1199 and the maximum rom_addr is 7679.
REQ-031 Outside write cycles, ram_we SHALL be 0; ram_addr and ram_din are don't-care.

Reset
REQ-032 clr=0 SHALL asynchronously force state=IDLE, busy=0, done=0, err=0, ram_we=0, rom_addr=0, ram_addr=0, ram_din=0, row counter=0, and pipeline valid bits=0.
REQ-033 Reset asserted mid-copy SHALL drop ram_we in the same instant; partial column contents remain and no done pulse is generated.
REQ-034 After clr deassertion the module SHALL accept req on the first clock edge.

Verification
REQ-035 Nominal load: req with level_col=3, dst_col=5, then f_tick -> rom_addr 90..119 on consecutive cycles; writes to 5,45,...,1165 start 2 cycles later; done pulses 1 cycle after the last write.
REQ-036 Invalid request: dst_col=40 -> err pulse, no ram_we, busy stays 0; level_col=255, dst_col=39 -> accepted with last rom_addr=7679 and last ram_addr=1199.
REQ-037 Beam conflict: video_on raised after 10 writes -> ram_we=0 immediately; the next f_tick restarts at row 0 and all 30 rows are written.
REQ-038 Simultaneous events: req together with f_tick -> copy waits for the following f_tick; a second req while busy -> ignored, exactly one done pulse.
REQ-039 Reset mid-copy: clr low after 15 writes -> all outputs 0 asynchronously and no done pulse; a new req after release completes normally.
REQ-040 Assertions SHALL hold throughout: ram_we implies video_on=0; done implies busy deasserts in the same cycle; ram_addr < MAP_COLS*MAP_ROWS whenever ram_we=1.

Source files
------------

// File: rtl/bg_column_loader_if.sv
// Bus bundle for the background column loader: engine handshake,
// level-ROM read port and bg_ram port-A write port.
interface bg_column_loader_if;
    logic        req;
    logic [7:0]  level_col;
    logic [5:0]  dst_col;
    logic        busy;
    logic        done;
    logic        err;
    logic [12:0] rom_addr;
    logic [8:0]  rom_data;
    logic [15:0] ram_addr;
    logic [8:0]  ram_din;
    logic        ram_we;

    modport master (
        output req, level_col, dst_col, rom_data,
        input  busy, done, err, rom_addr, ram_addr, ram_din, ram_we
    );

    modport slave (
        input  req, level_col, dst_col, rom_data,
        output busy, done, err, rom_addr, ram_addr, ram_din, ram_we
    );
endinterface

// File: rtl/bg_column_loader.sv
// Copies one level-ROM column into a bg_ram column during vertical blanking,
// restarting the column from row 0 whenever the beam re-enters the visible area.
module bg_column_loader #(
    parameter int unsigned MAP_COLS   = 40,
    parameter int unsigned MAP_ROWS   = 30,
    parameter int unsigned LEVEL_COLS = 256,
    parameter int unsigned ROM_LAT    = 2
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               f_tick,
    input  logic               video_on,
    bg_column_loader_if.slave  bus
);
    localparam int unsigned ROW_W  = (MAP_ROWS > 1) ? $clog2(MAP_ROWS) : 1;
    localparam int unsigned DR_W   = $clog2(ROM_LAT + 1);
    localparam int unsigned ROM_AW = 13;
    localparam int unsigned RAM_AW = 16;

    typedef enum logic [2:0] {IDLE, WAIT_VBL, READ, DRAIN, FINISH} state_e;

    state_e              state_q, state_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
    logic [RAM_AW-1:0]   rd_wa_q, rd_wa_d;
    logic [DR_W-1:0]     drain_q, drain_d;
    logic [7:0]          lvl_q, lvl_d;
    logic [5:0]          dst_q, dst_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [ROM_LAT-1:0]  vld_q, vld_d;
    logic [RAM_AW-1:0]   wa_q [ROM_LAT];
    logic [RAM_AW-1:0]   wa_d [ROM_LAT];
    logic                req_ok;

    assign req_ok = (32'(bus.dst_col) < MAP_COLS) && (32'(bus.level_col) < LEVEL_COLS);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= IDLE;
            row_q      <= '0;
            rom_addr_q <= '0;
            rd_wa_q    <= '0;
            drain_q    <= '0;
            lvl_q      <= '0;
            dst_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            vld_q      <= '0;
            for (int i = 0; i < int'(ROM_LAT); i++) wa_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            rom_addr_q <= rom_addr_d;
            rd_wa_q    <= rd_wa_d;
            drain_q    <= drain_d;
            lvl_q      <= lvl_d;
            dst_q      <= dst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            vld_q      <= vld_d;
            wa_q       <= wa_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        rom_addr_d = rom_addr_q;
        rd_wa_d    = rd_wa_q;
        drain_d    = drain_q;
        lvl_d      = lvl_q;
        dst_d      = dst_q;
        err_d      = 1'b0;

        // Write-address pipeline mirrors the ROM latency; stage 0 takes this cycle's read.
        for (int i = int'(ROM_LAT) - 1; i > 0; i--) begin
            vld_d[i] = vld_q[i-1];
            wa_d[i]  = wa_q[i-1];
        end
        vld_d[0] = 1'b0;
        wa_d[0]  = rd_wa_q;

        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    if (req_ok) begin
                        lvl_d   = bus.level_col;
                        dst_d   = bus.dst_col;
                        state_d = WAIT_VBL;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WAIT_VBL: begin
                if (f_tick) begin
                    state_d    = READ;
                    row_d      = '0;
                    rom_addr_d = ROM_AW'(lvl_q) * ROM_AW'(MAP_ROWS);
                    rd_wa_d    = RAM_AW'(dst_q);
                end
            end
            READ: begin
                vld_d[0] = 1'b1;
                if (row_q == ROW_W'(MAP_ROWS - 1)) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    row_d      = row_q + ROW_W'(1);
                    rom_addr_d = rom_addr_q + ROM_AW'(1);
                    rd_wa_d    = rd_wa_q + RAM_AW'(MAP_COLS);
                end
            end
            DRAIN: begin
                if (drain_q == DR_W'(ROM_LAT - 1)) state_d = FINISH;
                else                               drain_d = drain_q + DR_W'(1);
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Beam back in the visible area: drop everything in flight, wait for next blank.
        if (video_on && (state_q == READ || state_q == DRAIN)) begin
            state_d = WAIT_VBL;
            vld_d   = '0;
        end

        busy_d = (state_d == WAIT_VBL) || (state_d == READ) || (state_d == DRAIN);
        done_d = (state_d == FINISH);
    end

    // Write enable is gated by the beam directly so it drops in the same cycle.
    assign bus.ram_we   = vld_q[ROM_LAT-1] & ~video_on;
    assign bus.ram_addr = wa_q[ROM_LAT-1];
    assign bus.ram_din  = bus.ram_we ? bus.rom_data : '0;
    assign bus.rom_addr = rom_addr_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
endmodule
